// File: rtl/nios2_debug_ocimem_ctrl_if.sv
// Bus bundle between the debug-slave sysclk stage, the OCI memory engine and
// the debug RAM.
//   jdo / take_* : command word and 1-cycle action strobes into the engine
//   ram_*        : simple single-port RAM access (address, data, strobes)
//   MonDReg      : last read word returned to the JTAG side
//   monitor_*    : ready / sticky error status returned to the JTAG side
// master = command source plus RAM, slave = the memory engine.
interface nios2_debug_ocimem_ctrl_if #(
  parameter int unsigned ADDR_W = 8
);
  logic [37:0]       jdo;
  logic              take_action_ocimem_a;
  logic              take_action_ocimem_b;
  logic              take_no_action_ocimem_a;
  logic [ADDR_W-1:0] ram_address;
  logic [31:0]       ram_writedata;
  logic              ram_write;
  logic              ram_read;
  logic [31:0]       ram_readdata;
  logic [31:0]       MonDReg;
  logic              monitor_ready;
  logic              monitor_error;

  modport master (
    output jdo, take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a,
    output ram_readdata,
    input  ram_address, ram_writedata, ram_write, ram_read,
    input  MonDReg, monitor_ready, monitor_error
  );

  modport slave (
    input  jdo, take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a,
    input  ram_readdata,
    output ram_address, ram_writedata, ram_write, ram_read,
    output MonDReg, monitor_ready, monitor_error
  );
endinterface

// File: rtl/nios2_debug_ocimem_ctrl.sv
// Sysclk-domain OCI memory access engine: single-word debug RAM reads and
// writes driven by the ocimem action strobes, returning data and status.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous active-high reset
//   bus   : nios2_debug_ocimem_ctrl_if.slave (command strobes, RAM port, status)
// All outputs on bus are registered.
module nios2_debug_ocimem_ctrl #(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  nios2_debug_ocimem_ctrl_if.slave    bus
);

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned CNT_W    = 2;
  localparam int unsigned ADDR_LSB = 17;

  typedef enum logic [1:0] {IDLE, WRITE, READ, RWAIT} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   mon_q, mon_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                rd_inc_q, rd_inc_d;
  logic                ram_write_q, ram_write_d;
  logic                ram_read_q, ram_read_d;
  logic                ready_q, ready_d;
  logic                error_q, error_d;

  logic                st_a, st_b, st_n;
  logic                any_strobe, multi_strobe, drop;
  logic                rwait_done;
  logic                unused_jdo;

  assign st_a         = bus.take_action_ocimem_a;
  assign st_b         = bus.take_action_ocimem_b;
  assign st_n         = bus.take_no_action_ocimem_a;
  assign any_strobe   = st_a | st_b | st_n;
  assign multi_strobe = (st_a & st_b) | (st_a & st_n) | (st_b & st_n);
  // A strobe is dropped when the engine is busy or when it loses arbitration.
  assign drop         = ((state_q != IDLE) & any_strobe) | ((state_q == IDLE) & multi_strobe);
  // Counter is loaded with RD_LATENCY, so the edge it reaches 0 is when it holds 1.
  assign rwait_done   = (cnt_q == CNT_W'(1));
  assign unused_jdo   = ^{bus.jdo[37:36], bus.jdo[2:0]};

  // State and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      mon_q       <= '0;
      cnt_q       <= '0;
      rd_inc_q    <= 1'b0;
      ram_write_q <= 1'b0;
      ram_read_q  <= 1'b0;
      ready_q     <= 1'b1;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      mon_q       <= mon_d;
      cnt_q       <= cnt_d;
      rd_inc_q    <= rd_inc_d;
      ram_write_q <= ram_write_d;
      ram_read_q  <= ram_read_d;
      ready_q     <= ready_d;
      error_q     <= error_d;
    end
  end

  // Next-state: priority ocimem_a > ocimem_b > no_action_a in IDLE
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (st_a) begin
          if (bus.jdo[35]) state_d = READ;
        end else if (st_b) begin
          state_d = WRITE;
        end else if (st_n) begin
          state_d = READ;
        end
      end
      WRITE:   state_d = IDLE;
      READ:    state_d = RWAIT;
      RWAIT:   if (rwait_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of datapath registers and outputs
  always_comb begin
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    mon_d       = mon_q;
    cnt_d       = cnt_q;
    rd_inc_d    = rd_inc_q;
    ready_d     = ready_q;
    error_d     = error_q;
    // RAM strobes are high exactly for the cycle spent in WRITE / READ.
    ram_write_d = (state_d == WRITE);
    ram_read_d  = (state_d == READ);

    unique case (state_q)
      IDLE: begin
        if (st_a) begin
          addr_d = bus.jdo[ADDR_W+ADDR_LSB-1:ADDR_LSB];
          if (bus.jdo[34]) error_d = 1'b0;
          if (bus.jdo[35]) begin
            ready_d  = 1'b0;
            rd_inc_d = 1'b0;
          end
        end else if (st_b) begin
          wdata_d = bus.jdo[34:3];
          ready_d = 1'b0;
        end else if (st_n) begin
          ready_d  = 1'b0;
          rd_inc_d = 1'b1;
        end
      end
      WRITE: begin
        addr_d  = addr_q + ADDR_W'(1);
        ready_d = 1'b1;
      end
      READ: begin
        cnt_d = CNT_W'(RD_LATENCY);
      end
      RWAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (rwait_done) begin
          mon_d   = bus.ram_readdata;
          ready_d = 1'b1;
          // Streaming reads advance the address; explicit-address reads keep it.
          if (rd_inc_q) addr_d = addr_q + ADDR_W'(1);
        end
      end
      default: ;
    endcase

    // A drop overrides any clear requested in the same cycle.
    if (drop) error_d = 1'b1;
  end

  assign bus.ram_address   = addr_q;
  assign bus.ram_writedata = wdata_q;
  assign bus.ram_write     = ram_write_q;
  assign bus.ram_read      = ram_read_q;
  assign bus.MonDReg       = mon_q;
  assign bus.monitor_ready = ready_q;
  assign bus.monitor_error = error_q;

endmodule

// File: tb/tb_nios2_debug_ocimem_ctrl.sv
// Directed bench for nios2_debug_ocimem_ctrl with a small RAM model.
module tb_nios2_debug_ocimem_ctrl;

  localparam int unsigned AW  = 8;
  localparam int unsigned RDL = 2;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  int   wr_cnt;
  int   cyc;

  nios2_debug_ocimem_ctrl_if #(.ADDR_W(AW)) bus ();

  nios2_debug_ocimem_ctrl #(.ADDR_W(AW), .RD_LATENCY(RDL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: unwritten words read as C0DE00xx (xx = address)
  logic [31:0] mem     [256];
  logic        written [256];
  logic [31:0] pipe    [RDL];

  function automatic logic [31:0] rd_word(input logic [7:0] a);
    return written[a] ? mem[a] : (32'hC0DE_0000 | {24'h0, a});
  endfunction

  always @(posedge clk) begin
    if (bus.ram_write) begin
      mem[bus.ram_address]     <= bus.ram_writedata;
      written[bus.ram_address] <= 1'b1;
      wr_cnt                   <= wr_cnt + 1;
    end
    pipe[0] <= bus.ram_read ? rd_word(bus.ram_address) : 32'h0;
    for (int i = 1; i < RDL; i++) pipe[i] <= pipe[i-1];
  end
  assign bus.ram_readdata = pipe[RDL-1];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [37:0] jdo_a(input logic rd, input logic clr, input logic [7:0] a);
    logic [37:0] j;
    j        = '0;
    j[35]    = rd;
    j[34]    = clr;
    j[24:17] = a;
    return j;
  endfunction

  function automatic logic [37:0] jdo_b(input logic [31:0] d);
    logic [37:0] j;
    j       = '0;
    j[34:3] = d;
    return j;
  endfunction

  // One-cycle strobe; returns 1 time unit after the sampling edge
  task automatic pulse(input logic a, input logic b, input logic n, input logic [37:0] j);
    bus.jdo                     = j;
    bus.take_action_ocimem_a    = a;
    bus.take_action_ocimem_b    = b;
    bus.take_no_action_ocimem_a = n;
    @(posedge clk); #1;
    bus.take_action_ocimem_a    = 1'b0;
    bus.take_action_ocimem_b    = 1'b0;
    bus.take_no_action_ocimem_a = 1'b0;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // Bounded wait for monitor_ready; cycle count returned in cyc
  task automatic wait_ready(output int c);
    c = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      c++;
      if (bus.monitor_ready) break;
    end
    check("ready_timeout", 32'(bus.monitor_ready), 32'd1);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    wr_cnt = 0;
    for (int i = 0; i < 256; i++) begin
      written[i] = 1'b0;
      mem[i]     = 32'h0;
    end
    for (int i = 0; i < RDL; i++) pipe[i] = 32'h0;
    bus.jdo                     = '0;
    bus.take_action_ocimem_a    = 1'b0;
    bus.take_action_ocimem_b    = 1'b0;
    bus.take_no_action_ocimem_a = 1'b0;
    reset = 1'b1;
    step(3);

    // Reset state
    check("rst_addr",  32'(bus.ram_address),   32'h0);
    check("rst_mon",   bus.MonDReg,            32'h0);
    check("rst_wdata", bus.ram_writedata,      32'h0);
    check("rst_ready", 32'(bus.monitor_ready), 32'd1);
    check("rst_error", 32'(bus.monitor_error), 32'd0);
    check("rst_strb",  32'({bus.ram_write, bus.ram_read}), 32'd0);
    reset = 1'b0;
    step(1);

    // Load address 0x10 without read
    pulse(1'b1, 1'b0, 1'b0, jdo_a(1'b0, 1'b0, 8'h10));
    check("a_addr",  32'(bus.ram_address),   32'h10);
    check("a_ready", 32'(bus.monitor_ready), 32'd1);
    check("a_nord",  32'(bus.ram_read),      32'd0);

    // Write 0xDEADBEEF at 0x10
    pulse(1'b0, 1'b1, 1'b0, jdo_b(32'hDEADBEEF));
    check("w_strobe", 32'(bus.ram_write),     32'd1);
    check("w_addr",   32'(bus.ram_address),   32'h10);
    check("w_data",   bus.ram_writedata,      32'hDEADBEEF);
    check("w_busy",   32'(bus.monitor_ready), 32'd0);
    step(1);
    check("w_done",   32'(bus.monitor_ready), 32'd1);
    check("w_off",    32'(bus.ram_write),     32'd0);
    check("w_inc",    32'(bus.ram_address),   32'h11);
    check("w_mem",    mem[8'h10],             32'hDEADBEEF);
    check("w_hold",   bus.ram_writedata,      32'hDEADBEEF);
    check("w_mon",    bus.MonDReg,            32'h0);

    // Explicit-address read of 0x10
    pulse(1'b1, 1'b0, 1'b0, jdo_a(1'b1, 1'b0, 8'h10));
    check("r_strobe", 32'(bus.ram_read),      32'd1);
    check("r_addr",   32'(bus.ram_address),   32'h10);
    check("r_busy",   32'(bus.monitor_ready), 32'd0);
    wait_ready(cyc);
    check("r_lat",    32'(cyc),               32'(RDL + 1));
    check("r_data",   bus.MonDReg,            32'hDEADBEEF);
    check("r_keep",   32'(bus.ram_address),   32'h10);

    // Streaming reads across the address wrap
    pulse(1'b1, 1'b0, 1'b0, jdo_a(1'b0, 1'b0, 8'hFF));
    pulse(1'b0, 1'b0, 1'b1, '0);
    check("s1_addr",  32'(bus.ram_address),   32'hFF);
    check("s1_rd",    32'(bus.ram_read),      32'd1);
    wait_ready(cyc);
    check("s1_data",  bus.MonDReg,            32'hC0DE00FF);
    check("s1_wrap",  32'(bus.ram_address),   32'h00);
    pulse(1'b0, 1'b0, 1'b1, '0);
    check("s2_addr",  32'(bus.ram_address),   32'h00);
    wait_ready(cyc);
    check("s2_data",  bus.MonDReg,            32'hC0DE0000);
    check("s2_inc",   32'(bus.ram_address),   32'h01);
    check("s_noerr",  32'(bus.monitor_error), 32'd0);

    // Write while busy is dropped and flags the error
    pulse(1'b0, 1'b0, 1'b1, '0);
    pulse(1'b0, 1'b1, 1'b0, jdo_b(32'h5555AAAA));
    check("busy_err", 32'(bus.monitor_error), 32'd1);
    wait_ready(cyc);
    check("busy_nowr", 32'(wr_cnt),           32'd1);
    check("busy_data", bus.MonDReg,           32'hC0DE0001);
    check("busy_addr", 32'(bus.ram_address),  32'h02);
    step(2);
    check("err_stky", 32'(bus.monitor_error), 32'd1);
    pulse(1'b1, 1'b0, 1'b0, jdo_a(1'b0, 1'b1, 8'h20));
    check("err_clr",  32'(bus.monitor_error), 32'd0);
    check("clr_addr", 32'(bus.ram_address),   32'h20);

    // Simultaneous ocimem_a and ocimem_b: a wins, b dropped
    pulse(1'b1, 1'b1, 1'b0, jdo_a(1'b0, 1'b1, 8'h30));
    check("sim_addr", 32'(bus.ram_address),   32'h30);
    check("sim_err",  32'(bus.monitor_error), 32'd1);
    check("sim_rdy",  32'(bus.monitor_ready), 32'd1);
    check("sim_nowr", 32'(bus.ram_write),     32'd0);

    // Write with error set: error sticky, MonDReg unchanged
    pulse(1'b0, 1'b1, 1'b0, jdo_b(32'h0BADF00D));
    step(1);
    check("w2_mem",   mem[8'h30],             32'h0BADF00D);
    check("w2_mon",   bus.MonDReg,            32'hC0DE0001);
    check("w2_err",   32'(bus.monitor_error), 32'd1);
    check("w2_addr",  32'(bus.ram_address),   32'h31);

    // Reset during RWAIT aborts the read
    pulse(1'b1, 1'b0, 1'b0, jdo_a(1'b1, 1'b0, 8'h30));
    step(1);
    reset = 1'b1;
    #1;
    check("ra_mon",   bus.MonDReg,            32'h0);
    check("ra_rdy",   32'(bus.monitor_ready), 32'd1);
    check("ra_err",   32'(bus.monitor_error), 32'd0);
    check("ra_addr",  32'(bus.ram_address),   32'h0);
    check("ra_strb",  32'({bus.ram_write, bus.ram_read}), 32'd0);
    step(1);
    reset = 1'b0;
    step(RDL + 3);
    check("ra_nocap", bus.MonDReg,            32'h0);
    check("ra_idle",  32'(bus.monitor_ready), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
